debug_unit: RTL and testbench

Host-side control stage placed directly upstream of the pipeline. It receives command bytes from the UART receiver and loads program words into instruction memory. It also drives the pipeline's `pc_reset`/`pc_enable_in` inputs for run and single-step execution, and returns the fetched PC and instruction to the host through the UART transmitter.

---
 rtl/debug_unit.sv | 179 +++++++++++++++++
 tb/tb_debug_unit.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit.sv
// Host debug front-end: UART command decode, instruction-memory loader, run/step control and PC/instruction report.
// Optional cycle counter in the report is enabled with DEBUG_CYCLE_COUNT_EN.
module debug_unit #(
  parameter int IMEM_ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   pc_reset_out,
  output logic                   pc_enable_out,
  input  logic [31:0]            pc_addr_in,
  input  logic [31:0]            pc_instr_in,
  input  logic                   halt_in,
  output logic                   busy
);

`ifdef DEBUG_CYCLE_COUNT_EN
  localparam int RPT_BYTES = 12;
`else
  localparam int RPT_BYTES = 8;
`endif
  localparam int RPT_W = RPT_BYTES * 8;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_CNT, S_LOAD_BYTE, S_LOAD_WR, S_ACK,
    S_RUN_RST, S_RUN, S_STEP, S_SNAP, S_SEND, S_SEND_WAIT
  } state_t;

  state_t                 r_state;
  logic [8:0]             r_words_left;
  logic [IMEM_ADDR_W-1:0] r_idx;
  logic [1:0]             r_bcnt;
  logic [23:0]            r_shift;
  logic [RPT_W-1:0]       r_rpt;
  logic [3:0]             r_tx_left;

  logic                   w_stop;
  logic [RPT_W-1:0]       w_rpt;

  // halt and host 'H' in the same cycle collapse into one stop
  assign w_stop = halt_in | (rx_valid & (rx_data == 8'h48));
  assign busy   = (r_state != S_IDLE);

`ifdef DEBUG_CYCLE_COUNT_EN
  logic [31:0] r_cycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                r_cycles <= '0;
    else if (r_state == S_RUN_RST)            r_cycles <= '0;
    else if (pc_enable_out && r_cycles != '1) r_cycles <= r_cycles + 32'd1;
  end

  assign w_rpt = {pc_addr_in, pc_instr_in, r_cycles};
`else
  assign w_rpt = {pc_addr_in, pc_instr_in};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_words_left  <= '0;
      r_idx         <= '0;
      r_bcnt        <= '0;
      r_shift       <= '0;
      r_rpt         <= '0;
      r_tx_left     <= '0;
      tx_data       <= '0;
      tx_start      <= 1'b0;
      imem_we       <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      pc_reset_out  <= 1'b0;
      pc_enable_out <= 1'b0;
    end else begin
      tx_start     <= 1'b0;
      imem_we      <= 1'b0;
      pc_reset_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rx_valid) begin
            case (rx_data)
              8'h4C: r_state <= S_LOAD_CNT;
              8'h43: begin
                r_state      <= S_RUN_RST;
                pc_reset_out <= 1'b1;
              end
              8'h53: begin
                r_state       <= S_STEP;
                pc_enable_out <= 1'b1;
              end
              8'h52: r_state <= S_SNAP;
              default: r_state <= S_IDLE;
            endcase
          end
        end
        S_LOAD_CNT: begin
          if (rx_valid) begin
            r_words_left <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
            r_idx        <= '0;
            r_bcnt       <= '0;
            r_state      <= S_LOAD_BYTE;
          end
        end
        S_LOAD_BYTE: begin
          if (rx_valid) begin
            r_shift <= {r_shift[15:0], rx_data};
            r_bcnt  <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= r_idx;
              imem_wdata <= {r_shift, rx_data};
              r_state    <= S_LOAD_WR;
            end
          end
        end
        S_LOAD_WR: begin
          r_idx        <= r_idx + 1'b1;
          r_words_left <= r_words_left - 9'd1;
          r_state      <= (r_words_left == 9'd1) ? S_ACK : S_LOAD_BYTE;
        end
        S_ACK: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= 8'h4B;
            r_state  <= S_IDLE;
          end
        end
        S_RUN_RST: begin
          pc_enable_out <= 1'b1;
          r_state       <= S_RUN;
        end
        S_RUN: begin
          if (w_stop) begin
            pc_enable_out <= 1'b0;
            r_state       <= S_SNAP;
          end
        end
        S_STEP: begin
          pc_enable_out <= 1'b0;
          r_state       <= S_SNAP;
        end
        // Issue the first byte straight from the snapshot when the line is free
        S_SNAP: begin
          if (!tx_busy) begin
            tx_start  <= 1'b1;
            tx_data   <= w_rpt[RPT_W-1 -: 8];
            r_rpt     <= {w_rpt[RPT_W-9:0], 8'h00};
            r_tx_left <= 4'(RPT_BYTES - 1);
            r_state   <= S_SEND_WAIT;
          end else begin
            r_rpt     <= w_rpt;
            r_tx_left <= 4'(RPT_BYTES);
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (!tx_busy) begin
            tx_start  <= 1'b1;
            tx_data   <= r_rpt[RPT_W-1 -: 8];
            r_rpt     <= {r_rpt[RPT_W-9:0], 8'h00};
            r_tx_left <= r_tx_left - 4'd1;
            r_state   <= S_SEND_WAIT;
          end
        end
        // One dead cycle so tx_busy has risen before SEND samples it
        S_SEND_WAIT: r_state <= (r_tx_left == 4'd0) ? S_IDLE : S_SEND;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_unit.sv
// Directed bench for debug_unit (default build, 8-byte report) with a simple UART transmitter busy model.
module tb_debug_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        pc_reset_out;
  logic        pc_enable_out;
  logic [31:0] pc_addr_in = 32'h0;
  logic [31:0] pc_instr_in = 32'h0;
  logic        halt_in = 1'b0;
  logic        busy;

  logic        mdl_busy = 1'b0;
  logic        hold = 1'b0;
  int          busy_ctr = 0;

  int tests = 0;
  int fails = 0;
  int en_cnt = 0;
  int rst_cnt = 0;
  int proto_viol = 0;
  int hold_viol = 0;
  logic [7:0]  last_tx = 8'h00;
  logic [7:0]  tx_q[$];
  logic [39:0] wr_q[$];

  assign tx_busy = mdl_busy | hold;

  debug_unit #(.IMEM_ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .pc_reset_out(pc_reset_out), .pc_enable_out(pc_enable_out),
    .pc_addr_in(pc_addr_in), .pc_instr_in(pc_instr_in),
    .halt_in(halt_in), .busy(busy)
  );

  always #5 clk = ~clk;

  // transmitter: busy for four cycles after each start
  always @(posedge clk) begin
    if (tx_start) begin
      mdl_busy <= 1'b1;
      busy_ctr <= 3;
    end else if (busy_ctr != 0) begin
      busy_ctr <= busy_ctr - 1;
    end else begin
      mdl_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      last_tx = 8'h00;
    end else begin
      if (tx_start) begin
        tx_q.push_back(tx_data);
        if (tx_busy) proto_viol++;
        last_tx = tx_data;
      end else if (tx_data !== last_tx) begin
        hold_viol++;
      end
      if (imem_we) wr_q.push_back({imem_addr, imem_wdata});
      if (pc_enable_out) en_cnt++;
      if (pc_reset_out) rst_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    for (int k = 0; k < 400 && tx_q.size() < n; k++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; rx_valid = 1'b0; halt_in = 1'b0; hold = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    tx_q.delete(); wr_q.delete();
  endtask

  function automatic logic [63:0] pack8();
    logic [63:0] r;
    r = 'x;
    if (tx_q.size() >= 8)
      for (int i = 0; i < 8; i++) r[63-8*i -: 8] = tx_q[i];
    return r;
  endfunction

  task automatic test_reset();
    #2;
    tests++;
    if ({tx_data, tx_start, imem_we, imem_addr, imem_wdata, pc_reset_out, pc_enable_out, busy} !== 53'd0) begin
      fails++;
      $display("FAIL reset_outputs: tx_data=%h tx_start=%b we=%b addr=%h wdata=%h prst=%b pen=%b busy=%b, all must be 0",
               tx_data, tx_start, imem_we, imem_addr, imem_wdata, pc_reset_out, pc_enable_out, busy);
    end
    @(posedge clk); #1 reset = 1'b0;
    send_byte(8'h43);
    repeat (3) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (pc_enable_out !== 1'b0 || busy !== 1'b0 || pc_reset_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_async_run: pen=%b busy=%b prst=%b, required 0 0 0", pc_enable_out, busy, pc_reset_out);
    end
    @(posedge clk); #1 reset = 1'b0;
    tx_q.delete(); wr_q.delete();
  endtask

  task automatic test_ignore();
    int e0;
    e0 = en_cnt;
    tx_q.delete();
    send_byte(8'h00); send_byte(8'h48); send_byte(8'h4B); send_byte(8'hFF);
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || tx_q.size() != 0 || en_cnt != e0) begin
      fails++;
      $display("FAIL ignore_unknown: busy=%b tx=%0d en_cycles=%0d, required 0 0 0", busy, tx_q.size(), en_cnt - e0);
    end
  endtask

  task automatic test_load();
    tx_q.delete(); wr_q.delete();
    send_byte(8'h4C); send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
    tests++;
    if (imem_we !== 1'b1 || imem_addr !== 8'h00 || imem_wdata !== 32'h20080005) begin
      fails++;
      $display("FAIL load_we_latency: we=%b addr=%h wdata=%h, required 1 00 20080005", imem_we, imem_addr, imem_wdata);
    end
    send_byte(8'hAC); send_byte(8'h01); send_byte(8'h00); send_byte(8'h04);
    wait_tx(1);
    tests++;
    if (wr_q.size() != 2 || wr_q[0] !== {8'h00, 32'h20080005} || wr_q[1] !== {8'h01, 32'hAC010004}) begin
      fails++;
      $display("FAIL load_writes: count=%0d first=%h, required 2 writes 0020080005 01AC010004",
               wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 40'hx);
    end
    tests++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h4B) begin
      fails++;
      $display("FAIL load_ack: tx count=%0d byte=%h, required 1 byte 4B", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL load_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_load_256();
    int bad;
    logic [31:0] w;
    logic [7:0]  i8;
    tx_q.delete(); wr_q.delete();
    send_byte(8'h4C); send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      i8 = 8'(i);
      w = {i8, ~i8, 8'h5A, i8};
      send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
    end
    wait_tx(1);
    bad = 0;
    if (wr_q.size() != 256) bad++;
    else
      for (int i = 0; i < 256; i++) begin
        i8 = 8'(i);
        if (wr_q[i] !== {i8, i8, ~i8, 8'h5A, i8}) bad++;
      end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL load_256_words: writes=%0d bad=%0d, required 256 writes 0 bad", wr_q.size(), bad);
    end
    tests++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h4B) begin
      fails++;
      $display("FAIL load_256_ack: tx count=%0d, required single 4B", tx_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_step();
    int e0, r0;
    do_reset();
    pc_addr_in = 32'h00000004; pc_instr_in = 32'h20080005;
    e0 = en_cnt; r0 = rst_cnt;
    send_byte(8'h53);
    tests++;
    if (pc_enable_out !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL step_enable_k1: pen=%b busy=%b, required 1 1", pc_enable_out, busy);
    end
    @(posedge clk); #1;
    tests++;
    if (pc_enable_out !== 1'b0) begin
      fails++;
      $display("FAIL step_enable_k2: pen=%b, required 0", pc_enable_out);
    end
    @(posedge clk); #1;
    tests++;
    if (tx_start !== 1'b1 || tx_data !== 8'h00) begin
      fails++;
      $display("FAIL step_first_tx_k3: tx_start=%b tx_data=%h, required 1 00", tx_start, tx_data);
    end
    wait_tx(8);
    tests++;
    if (pack8() !== 64'h00000004_20080005) begin
      fails++;
      $display("FAIL step_report: got %h, required 0000000420080005", pack8());
    end
    tests++;
    if (en_cnt - e0 != 1 || rst_cnt != r0) begin
      fails++;
      $display("FAIL step_pulses: enable cycles=%0d pc_reset cycles=%0d, required 1 0", en_cnt - e0, rst_cnt - r0);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_run_halt();
    int e0, r0;
    tx_q.delete();
    pc_addr_in = 32'h0000002C; pc_instr_in = 32'hFFFFFFFF;
    e0 = en_cnt; r0 = rst_cnt;
    send_byte(8'h43);
    tests++;
    if (pc_reset_out !== 1'b1 || pc_enable_out !== 1'b0) begin
      fails++;
      $display("FAIL run_reset_k1: prst=%b pen=%b, required 1 0", pc_reset_out, pc_enable_out);
    end
    @(posedge clk); #1;
    tests++;
    if (pc_reset_out !== 1'b0 || pc_enable_out !== 1'b1) begin
      fails++;
      $display("FAIL run_enable_k2: prst=%b pen=%b, required 0 1", pc_reset_out, pc_enable_out);
    end
    repeat (10) begin @(posedge clk); #1; end
    halt_in = 1'b1;
    @(posedge clk); #1;
    halt_in = 1'b0;
    tests++;
    if (pc_enable_out !== 1'b0) begin
      fails++;
      $display("FAIL run_halt_drop: pen=%b, required 0", pc_enable_out);
    end
    wait_tx(8);
    tests++;
    if (en_cnt - e0 != 11 || rst_cnt - r0 != 1) begin
      fails++;
      $display("FAIL run_pulse_counts: enable cycles=%0d pc_reset cycles=%0d, required 11 1", en_cnt - e0, rst_cnt - r0);
    end
    tests++;
    if (pack8() !== 64'h0000002C_FFFFFFFF) begin
      fails++;
      $display("FAIL run_report: got %h, required 0000002CFFFFFFFF", pack8());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_host_stop();
    tx_q.delete();
    pc_addr_in = 32'h00000100; pc_instr_in = 32'h12345678;
    send_byte(8'h43);
    repeat (4) begin @(posedge clk); #1; end
    rx_data = 8'h48; rx_valid = 1'b1;
    tests++;
    if (pc_enable_out !== 1'b1) begin
      fails++;
      $display("FAIL host_stop_running: pen=%b, required 1", pc_enable_out);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    tests++;
    if (pc_enable_out !== 1'b0) begin
      fails++;
      $display("FAIL host_stop_drop: pen=%b, required 0", pc_enable_out);
    end
    wait_tx(8);
    tests++;
    if (pack8() !== 64'h00000100_12345678) begin
      fails++;
      $display("FAIL host_stop_report: got %h, required 0000010012345678", pack8());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_stop_both();
    tx_q.delete();
    pc_addr_in = 32'h00000008; pc_instr_in = 32'hDEADBEEF;
    send_byte(8'h43);
    repeat (3) begin @(posedge clk); #1; end
    rx_data = 8'h48; rx_valid = 1'b1; halt_in = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; halt_in = 1'b0;
    wait_tx(8);
    repeat (20) @(negedge clk);
    tests++;
    if (tx_q.size() != 8 || busy !== 1'b0) begin
      fails++;
      $display("FAIL stop_both_single: tx bytes=%0d busy=%b, required 8 0", tx_q.size(), busy);
    end
    tests++;
    if (pack8() !== 64'h00000008_DEADBEEF) begin
      fails++;
      $display("FAIL stop_both_report: got %h, required 00000008DEADBEEF", pack8());
    end
  endtask

  task automatic test_reset_mid_load();
    tx_q.delete(); wr_q.delete();
    send_byte(8'h4C); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    reset = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || imem_we !== 1'b0) begin
      fails++;
      $display("FAIL midload_reset_out: busy=%b we=%b, required 0 0", busy, imem_we);
    end
    @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    tests++;
    if (wr_q.size() != 0 || tx_q.size() != 0) begin
      fails++;
      $display("FAIL midload_discard: writes=%0d tx=%0d, required 0 0", wr_q.size(), tx_q.size());
    end
    pc_addr_in = 32'h00000010; pc_instr_in = 32'h8C220000;
    send_byte(8'h52);
    wait_tx(8);
    repeat (20) @(negedge clk);
    tests++;
    if (tx_q.size() != 8 || pack8() !== 64'h00000010_8C220000) begin
      fails++;
      $display("FAIL midload_then_report: count=%0d got %h, required 8 bytes 000000108C220000", tx_q.size(), pack8());
    end
  endtask

  task automatic test_back_pressure();
    tx_q.delete();
    pc_addr_in = 32'hCAFE0000; pc_instr_in = 32'h0BADF00D;
    send_byte(8'h52);
    wait_tx(1);
    @(posedge clk); #1;
    hold = 1'b1;
    send_byte(8'h4C);
    repeat (50) @(negedge clk);
    tests++;
    if (tx_q.size() != 1) begin
      fails++;
      $display("FAIL backpressure_hold: tx bytes=%0d during busy, required 1", tx_q.size());
    end
    hold = 1'b0;
    wait_tx(8);
    repeat (10) @(negedge clk);
    tests++;
    if (tx_q.size() != 8 || pack8() !== 64'hCAFE0000_0BADF00D) begin
      fails++;
      $display("FAIL backpressure_report: count=%0d got %h, required 8 bytes CAFE00000BADF00D", tx_q.size(), pack8());
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL backpressure_rx_ignored: busy=%b, required 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_ignore();
    test_load();
    test_load_256();
    test_step();
    test_run_halt();
    test_host_stop();
    test_stop_both();
    test_reset_mid_load();
    test_back_pressure();
    tests++;
    if (proto_viol != 0) begin
      fails++;
      $display("FAIL tx_start_when_busy: %0d starts while busy, required 0", proto_viol);
    end
    tests++;
    if (hold_viol != 0) begin
      fails++;
      $display("FAIL tx_data_stable: %0d changes between starts, required 0", hold_viol);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
